mmio_timer: RTL and testbench
=============================

# mmio_timer

Memory-mapped timer/counter peripheral that acts as a responder on the CPU data-bus side, answering load/store requests issued by the core. It decodes a 16-byte register window, returns read data with a one-wait-state request/acknowledge handshake, and runs a prescaled 32-bit down/up counter that raises an interrupt flag on expiry. It sits beside the data memory on the load/store path and is selected by address decode.

## Interface
- BASE_ADDR, 32'h0000_7F00, word-aligned base of the 16-byte register window
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req  in  1  access request; held high by the initiator until ack is seen
- we  in  1  1 = store, 0 = load; sampled with req
- addr  in  32  byte address; bits [1:0] ignored
- wdata  in  32  store data
- be  in  4  byte enables for stores, be[0] = bits [7:0]
- hit  out  1  combinational: addr[31:4] == BASE_ADDR[31:4]
- rdata  out  32  registered load data, valid while ack = 1
- ack  out  1  one-cycle completion pulse
- irq  out  1  pending & CTRL.IM

## Operation
- Register map (offset): 0x0 CTRL, 0x4 PRESET, 0x8 COUNT (read-only), 0xC STATUS.
- CTRL: [0] EN, [2:1] MODE (00 one-shot down, 01 auto-reload down, 10 free-run up, 11 treated as 00), [3] IM, [15:8] PRESCALE; other bits read 0.
- STATUS: [0] pending; write 1 with be[0] = 1 clears; other bits read 0.
- Stores honour be per byte on CTRL and PRESET; stores to COUNT are ignored but still acked.
- Bus FSM: B_IDLE -> B_ACK when req & hit; B_ACK -> B_WAIT unconditionally; B_WAIT -> B_IDLE when req = 0. Requests with hit = 0 are ignored (no ack).
- Store commits on the B_IDLE -> B_ACK edge; rdata is captured on that same edge.
- Counter FSM: C_IDLE, C_LOAD, C_RUN.
  - C_IDLE -> C_LOAD when EN = 1. C_LOAD: COUNT <= PRESET (MODE 10: COUNT <= 0), prescaler <= 0, -> C_RUN.
  - C_RUN: prescaler increments each cycle; tick when prescaler == PRESCALE, prescaler <= 0. Tick period is PRESCALE+1 cycles.
  - Down modes, on tick: COUNT != 0 -> COUNT - 1; COUNT == 0 -> pending <= 1, then one-shot: EN <= 0, -> C_IDLE, COUNT holds 0; auto-reload: COUNT <= PRESET, stay.
  - Free-run, on tick: COUNT + 1 mod 2^32; wrap 0xFFFF_FFFF -> 0 sets pending.
  - EN written 0 in any state -> C_IDLE on the next edge, COUNT holds.
- Precedence: hardware pending-set beats a same-cycle STATUS clear. A store to CTRL that sets EN while in C_RUN does not restart. PRESET writes during C_RUN take effect only at the next reload. PRESET = 0 in auto-reload sets pending on every tick.

## Timing
- Reset: ack = 0, rdata = 0, irq = 0, all registers 0, both FSMs in idle state. Reset wins over any concurrent store.
- Read latency: req sampled at edge N. ack = 1 and rdata are valid in the cycle after edge N, for exactly one cycle.
- Back-to-back access: req must drop for at least one cycle. The minimum access period is 3 cycles.
- Reset mid-handshake: ack is 0 after the reset edge. A store sampled on the reset edge is discarded.
- irq is combinational from registered pending and IM, with no extra latency. pending is visible the cycle after the expiry tick.
- The first tick occurs PRESCALE+1 cycles after entering C_RUN.
- The write to EN lands at edge N. C_LOAD occurs in cycle N+1, and C_RUN starts at N+2.

## Test plan
- Reset, then load each offset -> rdata = 0 and ack pulses exactly 1 cycle after req, with irq = 0.
- Store PRESET = 3, then store CTRL = 0x0000_0009 (EN, one-shot, IM, PRESCALE 0). Expected: COUNT reads 3, 2, 1, 0 on successive ticks. pending and irq rise on the tick after COUNT reaches 0, and EN then reads 0.
- Auto-reload with PRESET = 2 and PRESCALE = 1 -> irq rises every 6 cycles. Storing STATUS = 1 clears it. A clear issued in the expiry cycle leaves pending = 1.
- Free-run with PRESCALE = 0: force COUNT near wrap using a short run from a reset-time COUNT of 0 (bench force allowed). Expected: wrap 0xFFFF_FFFF -> 0 sets pending.
- Store with be = 4'b0010, wdata = 0x0000_0400 to CTRL -> PRESCALE = 4 and other fields unchanged. A store to COUNT is acked and COUNT is unchanged.
- req to BASE_ADDR + 0x10 -> no ack and hit = 0. req held high for 5 cycles -> only one ack. Assert rst during B_ACK -> ack = 0 next cycle and all registers = 0.

Source files
------------

// File: rtl/mmio_timer_if.sv
// Load/store responder bus between the core's data port and the timer peripheral.
// The core drives the request side; the timer returns hit, ack, rdata and irq.
interface mmio_timer_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        hit;
  logic [31:0] rdata;
  logic        ack;
  logic        irq;

  modport master (output req, we, addr, wdata, be, input hit, rdata, ack, irq);
  modport slave  (input req, we, addr, wdata, be, output hit, rdata, ack, irq);
endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped prescaled 32-bit timer: CTRL/PRESET/COUNT/STATUS window with a
// one-wait-state req/ack bus and one-shot, auto-reload and free-running modes.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input logic         clk,
  input logic         rst,
  mmio_timer_if.slave bus
);

  typedef enum logic [1:0] {B_IDLE = 2'd0, B_ACK = 2'd1, B_WAIT = 2'd2} bstate_t;
  typedef enum logic [1:0] {C_IDLE = 2'd0, C_LOAD = 2'd1, C_RUN = 2'd2} cstate_t;

  bstate_t     bstate_q, bstate_d;
  cstate_t     cstate_q, cstate_d;
  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;
  logic        en_q, en_d;
  logic [1:0]  mode_q, mode_d;
  logic        im_q, im_d;
  logic [7:0]  prescale_q, prescale_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic [7:0]  psc_q, psc_d;
  logic        pending_q, pending_d;

  logic        hit_s;
  logic        wr_s;
  logic        hw_set_s;
  logic        clr_s;
  logic        free_run_s;
  logic [31:0] rd_mux_s;
  logic        unused_s;

  assign hit_s      = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign free_run_s = (mode_q == 2'b10);
  assign unused_s   = ^bus.addr[1:0];

  assign bus.hit   = hit_s;
  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;
  assign bus.irq   = pending_q & im_q;

  // Register read multiplexer on the word offset.
  always_comb begin
    rd_mux_s = 32'h0000_0000;
    case (bus.addr[3:2])
      2'd0:    rd_mux_s = {16'h0000, prescale_q, 4'h0, im_q, mode_q, en_q};
      2'd1:    rd_mux_s = preset_q;
      2'd2:    rd_mux_s = count_q;
      2'd3:    rd_mux_s = {31'h0000_0000, pending_q};
      default: rd_mux_s = 32'h0000_0000;
    endcase
  end

  // Next-state logic: bus handshake, counter sequencing, then register stores.
  always_comb begin
    bstate_d   = bstate_q;
    cstate_d   = cstate_q;
    ack_d      = 1'b0;
    rdata_d    = rdata_q;
    en_d       = en_q;
    mode_d     = mode_q;
    im_d       = im_q;
    prescale_d = prescale_q;
    preset_d   = preset_q;
    count_d    = count_q;
    psc_d      = psc_q;
    wr_s       = 1'b0;
    hw_set_s   = 1'b0;
    clr_s      = 1'b0;

    case (bstate_q)
      B_IDLE: begin
        if (bus.req && hit_s) begin
          bstate_d = B_ACK;
          ack_d    = 1'b1;
          rdata_d  = rd_mux_s;
          wr_s     = bus.we;
        end else begin
          bstate_d = B_IDLE;
        end
      end
      B_ACK:   bstate_d = B_WAIT;
      B_WAIT:  bstate_d = bus.req ? B_WAIT : B_IDLE;
      default: bstate_d = B_IDLE;
    endcase

    case (cstate_q)
      C_IDLE: cstate_d = en_q ? C_LOAD : C_IDLE;
      C_LOAD: begin
        if (!en_q) begin
          cstate_d = C_IDLE;
        end else begin
          count_d  = free_run_s ? 32'h0000_0000 : preset_q;
          psc_d    = 8'h00;
          cstate_d = C_RUN;
        end
      end
      C_RUN: begin
        if (!en_q) begin
          cstate_d = C_IDLE;
        end else if (psc_q != prescale_q) begin
          psc_d = psc_q + 8'h01;
        end else begin
          psc_d = 8'h00;
          if (free_run_s) begin
            count_d  = count_q + 32'h0000_0001;
            hw_set_s = (count_q == 32'hFFFF_FFFF);
          end else if (count_q != 32'h0000_0000) begin
            count_d = count_q - 32'h0000_0001;
          end else begin
            hw_set_s = 1'b1;
            // Mode 11 behaves as one-shot: only 01 reloads.
            if (mode_q == 2'b01) begin
              count_d = preset_q;
            end else begin
              en_d     = 1'b0;
              cstate_d = C_IDLE;
            end
          end
        end
      end
      default: cstate_d = C_IDLE;
    endcase

    if (wr_s) begin
      case (bus.addr[3:2])
        2'd0: begin
          en_d       = bus.be[0] ? bus.wdata[0]    : en_d;
          mode_d     = bus.be[0] ? bus.wdata[2:1]  : mode_q;
          im_d       = bus.be[0] ? bus.wdata[3]    : im_q;
          prescale_d = bus.be[1] ? bus.wdata[15:8] : prescale_q;
        end
        2'd1: begin
          preset_d[7:0]   = bus.be[0] ? bus.wdata[7:0]   : preset_q[7:0];
          preset_d[15:8]  = bus.be[1] ? bus.wdata[15:8]  : preset_q[15:8];
          preset_d[23:16] = bus.be[2] ? bus.wdata[23:16] : preset_q[23:16];
          preset_d[31:24] = bus.be[3] ? bus.wdata[31:24] : preset_q[31:24];
        end
        2'd2:    clr_s = 1'b0;
        2'd3:    clr_s = bus.be[0] & bus.wdata[0];
        default: clr_s = 1'b0;
      endcase
    end else begin
      clr_s = 1'b0;
    end

    // A hardware expiry always wins over a clear landing in the same cycle.
    if (hw_set_s) begin
      pending_d = 1'b1;
    end else if (clr_s) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      bstate_q   <= B_IDLE;
      cstate_q   <= C_IDLE;
      ack_q      <= 1'b0;
      rdata_q    <= 32'h0000_0000;
      en_q       <= 1'b0;
      mode_q     <= 2'b00;
      im_q       <= 1'b0;
      prescale_q <= 8'h00;
      preset_q   <= 32'h0000_0000;
      count_q    <= 32'h0000_0000;
      psc_q      <= 8'h00;
      pending_q  <= 1'b0;
    end else begin
      bstate_q   <= bstate_d;
      cstate_q   <= cstate_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      en_q       <= en_d;
      mode_q     <= mode_d;
      im_q       <= im_d;
      prescale_q <= prescale_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      psc_q      <= psc_d;
      pending_q  <= pending_d;
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: reset, one-shot, auto-reload, free-run wrap,
// byte enables, address miss, held request and reset during a handshake.
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic clk;
  logic rst;
  mmio_timer_if bif ();

  mmio_timer #(.BASE_ADDR(BASE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int          checks;
  int          failures;
  logic [31:0] rd;
  int          lat;
  logic        aa;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // One complete access; called and returns at #1 after a rising edge.
  task automatic bus_op(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, output logic [31:0] r, output int l,
                        output logic ack_after);
    bif.req = 1'b1; bif.we = w; bif.addr = a; bif.wdata = d; bif.be = b;
    l = 0;
    while (bif.ack !== 1'b1 && l < 8) begin
      @(posedge clk); #1;
      l++;
    end
    r = bif.rdata;
    checks++;
    if (l >= 8) begin
      $display("FAIL bus_timeout: addr=%h got no ack within %0d cycles, required 1", a, l);
      failures++;
    end
    bif.req = 1'b0; bif.we = 1'b0;
    @(posedge clk); #1;
    ack_after = bif.ack;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; bif.req = 1'b0; bif.we = 1'b0;
    bif.addr = BASE; bif.wdata = 32'h0000_0000; bif.be = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 4;
    if (bif.ack !== 1'b0) begin $display("FAIL reset_ack: got %b required 0", bif.ack); failures++; end
    if (bif.rdata !== 32'h0) begin $display("FAIL reset_rdata: got %h required 0", bif.rdata); failures++; end
    if (bif.irq !== 1'b0) begin $display("FAIL reset_irq: got %b required 0", bif.irq); failures++; end
    if (bif.hit !== 1'b1) begin $display("FAIL reset_hit: got %b required 1", bif.hit); failures++; end
    for (int i = 0; i < 4; i++) begin
      bus_op(1'b0, BASE + 32'(i * 4), 32'h0, 4'h0, rd, lat, aa);
      checks += 4;
      if (rd !== 32'h0) begin $display("FAIL reset_read off=%0d: got %h required 0", i * 4, rd); failures++; end
      if (lat !== 1) begin $display("FAIL reset_latency off=%0d: got %0d required 1", i * 4, lat); failures++; end
      if (aa !== 1'b0) begin $display("FAIL reset_ack_width off=%0d: got %b required 0", i * 4, aa); failures++; end
      if (bif.irq !== 1'b0) begin $display("FAIL reset_irq_read: got %b required 0", bif.irq); failures++; end
    end
  endtask

  task automatic test_oneshot();
    bus_op(1'b1, BASE + 32'h4, 32'h0000_0003, 4'hF, rd, lat, aa);
    bus_op(1'b1, BASE + 32'h0, 32'h0000_0009, 4'hF, rd, lat, aa);
    checks++;
    if (dut.count_q !== 32'd3) begin $display("FAIL oneshot_load: got %h required 3", dut.count_q); failures++; end
    for (int k = 2; k >= 0; k--) begin
      @(posedge clk); #1;
      checks += 2;
      if (dut.count_q !== 32'(k)) begin $display("FAIL oneshot_count: got %h required %h", dut.count_q, k); failures++; end
      if (bif.irq !== 1'b0) begin $display("FAIL oneshot_early_irq: got %b required 0", bif.irq); failures++; end
    end
    @(posedge clk); #1;
    checks += 2;
    if (bif.irq !== 1'b1) begin $display("FAIL oneshot_irq: got %b required 1", bif.irq); failures++; end
    if (dut.count_q !== 32'h0) begin $display("FAIL oneshot_hold: got %h required 0", dut.count_q); failures++; end
    bus_op(1'b0, BASE + 32'h0, 32'h0, 4'h0, rd, lat, aa);
    checks++;
    if (rd !== 32'h0000_0008) begin $display("FAIL oneshot_en_clear: got %h required 00000008", rd); failures++; end
    bus_op(1'b0, BASE + 32'hC, 32'h0, 4'h0, rd, lat, aa);
    checks++;
    if (rd !== 32'h0000_0001) begin $display("FAIL oneshot_status: got %h required 1", rd); failures++; end
    bus_op(1'b1, BASE + 32'hC, 32'h0000_0001, 4'h1, rd, lat, aa);
    checks++;
    if (bif.irq !== 1'b0) begin $display("FAIL oneshot_clear: got %b required 0", bif.irq); failures++; end
  endtask

  task automatic test_autoreload();
    int cyc;
    bus_op(1'b1, BASE + 32'h4, 32'h0000_0002, 4'hF, rd, lat, aa);
    bus_op(1'b1, BASE + 32'h0, 32'h0000_010B, 4'hF, rd, lat, aa);
    cyc = 0;
    while (bif.irq !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
    checks++;
    if (cyc !== 6) begin $display("FAIL autoreload_first: got %0d cycles required 6", cyc); failures++; end
    bus_op(1'b1, BASE + 32'hC, 32'h0000_0001, 4'h1, rd, lat, aa);
    checks++;
    if (bif.irq !== 1'b0) begin $display("FAIL autoreload_clear: got %b required 0", bif.irq); failures++; end
    cyc = 0;
    while (bif.irq !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
    checks++;
    if (cyc !== 3) begin $display("FAIL autoreload_period: got %0d cycles required 3", cyc); failures++; end
    // Land the next clear exactly on the expiry edge, six cycles after this rise.
    repeat (5) begin @(posedge clk); #1; end
    bus_op(1'b1, BASE + 32'hC, 32'h0000_0001, 4'h1, rd, lat, aa);
    checks++;
    if (bif.irq !== 1'b1) begin $display("FAIL autoreload_clear_race: got %b required 1", bif.irq); failures++; end
    bus_op(1'b1, BASE + 32'h0, 32'h0000_0000, 4'hF, rd, lat, aa);
    bus_op(1'b1, BASE + 32'hC, 32'h0000_0001, 4'h1, rd, lat, aa);
    checks++;
    if (bif.irq !== 1'b0) begin $display("FAIL autoreload_stop: got %b required 0", bif.irq); failures++; end
  endtask

  task automatic test_freerun();
    bus_op(1'b1, BASE + 32'h0, 32'h0000_000D, 4'hF, rd, lat, aa);
    checks++;
    if (dut.count_q !== 32'h0) begin $display("FAIL freerun_start: got %h required 0", dut.count_q); failures++; end
    force dut.count_q = 32'hFFFF_FFFD;
    @(negedge clk);
    release dut.count_q;
    @(posedge clk); #1;
    checks += 2;
    if (dut.count_q !== 32'hFFFF_FFFE) begin $display("FAIL freerun_inc: got %h required fffffffe", dut.count_q); failures++; end
    if (bif.irq !== 1'b0) begin $display("FAIL freerun_early: got %b required 0", bif.irq); failures++; end
    @(posedge clk); #1;
    checks++;
    if (bif.irq !== 1'b0) begin $display("FAIL freerun_max: got %b required 0", bif.irq); failures++; end
    @(posedge clk); #1;
    checks += 2;
    if (dut.count_q !== 32'h0) begin $display("FAIL freerun_wrap: got %h required 0", dut.count_q); failures++; end
    if (bif.irq !== 1'b1) begin $display("FAIL freerun_irq: got %b required 1", bif.irq); failures++; end
    bus_op(1'b1, BASE + 32'h0, 32'h0000_0000, 4'hF, rd, lat, aa);
    bus_op(1'b1, BASE + 32'hC, 32'h0000_0001, 4'h1, rd, lat, aa);
  endtask

  task automatic test_byte_enable();
    do_reset();
    bus_op(1'b1, BASE + 32'h0, 32'h0000_0308, 4'hF, rd, lat, aa);
    bus_op(1'b1, BASE + 32'h0, 32'h0000_0400, 4'b0010, rd, lat, aa);
    bus_op(1'b0, BASE + 32'h0, 32'h0, 4'h0, rd, lat, aa);
    checks++;
    if (rd !== 32'h0000_0408) begin $display("FAIL be_ctrl: got %h required 00000408", rd); failures++; end
    bus_op(1'b1, BASE + 32'h4, 32'h1122_3344, 4'hF, rd, lat, aa);
    bus_op(1'b1, BASE + 32'h4, 32'h00AA_0000, 4'b0100, rd, lat, aa);
    bus_op(1'b0, BASE + 32'h4, 32'h0, 4'h0, rd, lat, aa);
    checks++;
    if (rd !== 32'h11AA_3344) begin $display("FAIL be_preset: got %h required 11aa3344", rd); failures++; end
    bus_op(1'b1, BASE + 32'h8, 32'hDEAD_BEEF, 4'hF, rd, lat, aa);
    checks++;
    if (lat !== 1) begin $display("FAIL count_store_ack: got latency %0d required 1", lat); failures++; end
    bus_op(1'b0, BASE + 32'h8, 32'h0, 4'h0, rd, lat, aa);
    checks++;
    if (rd !== 32'h0) begin $display("FAIL count_readonly: got %h required 0", rd); failures++; end
  endtask

  task automatic test_miss_and_hold();
    int acks;
    bif.req = 1'b1; bif.we = 1'b0; bif.addr = BASE + 32'h10;
    #1;
    checks++;
    if (bif.hit !== 1'b0) begin $display("FAIL miss_hit: got %b required 0", bif.hit); failures++; end
    acks = 0;
    repeat (4) begin @(posedge clk); #1; if (bif.ack === 1'b1) acks++; end
    checks++;
    if (acks !== 0) begin $display("FAIL miss_ack: got %0d acks required 0", acks); failures++; end
    bif.addr = BASE + 32'h4;
    acks = 0;
    repeat (5) begin @(posedge clk); #1; if (bif.ack === 1'b1) acks++; end
    checks++;
    if (acks !== 1) begin $display("FAIL held_req: got %0d acks required 1", acks); failures++; end
    bif.req = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset_mid();
    bus_op(1'b1, BASE + 32'h4, 32'h0000_0055, 4'hF, rd, lat, aa);
    bus_op(1'b1, BASE + 32'h0, 32'h0000_050A, 4'hF, rd, lat, aa);
    bif.req = 1'b1; bif.we = 1'b1; bif.addr = BASE + 32'h4; bif.wdata = 32'h0000_AAAA; bif.be = 4'hF;
    @(posedge clk); #1;
    checks++;
    if (bif.ack !== 1'b1) begin $display("FAIL mid_ack_pre: got %b required 1", bif.ack); failures++; end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bif.ack !== 1'b0) begin $display("FAIL mid_ack_post: got %b required 0", bif.ack); failures++; end
    rst = 1'b0; bif.req = 1'b0; bif.we = 1'b0;
    @(posedge clk); #1;
    // A store presented on the reset edge from idle must be dropped.
    rst = 1'b1; bif.req = 1'b1; bif.we = 1'b1; bif.wdata = 32'h0000_0077;
    @(posedge clk); #1;
    rst = 1'b0; bif.req = 1'b0; bif.we = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      bus_op(1'b0, BASE + 32'(i * 4), 32'h0, 4'h0, rd, lat, aa);
      checks++;
      if (rd !== 32'h0) begin $display("FAIL mid_reg off=%0d: got %h required 0", i * 4, rd); failures++; end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; bif.req = 1'b0; bif.we = 1'b0;
    bif.addr = BASE; bif.wdata = 32'h0; bif.be = 4'h0;
    test_reset();
    test_oneshot();
    test_autoreload();
    test_freerun();
    test_byte_enable();
    test_miss_and_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
